// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: machine width, reset vector default and
// the program-address type used by fetch, branch and PC logic.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] pc_t;

    localparam pc_t RESET_VECTOR_DEFAULT = XLEN'(0);

endpackage : riscv_pkg

// File: rtl/pc_next_mux.sv
// Next-PC select: chooses the branch/jump target or the sequential address.
module pc_next_mux
    import riscv_pkg::*;
#(
    parameter int unsigned bitwidth = XLEN
) (
    input  logic [bitwidth-1:0] pc_plus_4,
    input  logic [bitwidth-1:0] branch_target,
    input  logic                branch_decision,
    output logic [bitwidth-1:0] next_pc_c
);

    always_comb begin
        next_pc_c = pc_plus_4;
        if (branch_decision) begin
            next_pc_c = branch_target;
        end
    end

endmodule : pc_next_mux

// File: rtl/program_counter.sv
// Architectural PC register: loads the selected next address every rising edge,
// with a synchronous reset that overrides any pending branch.
module program_counter
    import riscv_pkg::*;
#(
    parameter int unsigned          bitwidth     = XLEN,
    parameter logic [bitwidth-1:0]  RESET_VECTOR = bitwidth'(RESET_VECTOR_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [bitwidth-1:0] pc_plus_4,
    input  logic [bitwidth-1:0] branch_target,
    input  logic                branch_decision,
    output logic [bitwidth-1:0] PC
);

    logic [bitwidth-1:0] next_pc_c;

    pc_next_mux #(
        .bitwidth (bitwidth)
    ) u_pc_next_mux (
        .pc_plus_4       (pc_plus_4),
        .branch_target   (branch_target),
        .branch_decision (branch_decision),
        .next_pc_c       (next_pc_c)
    );

    // Addresses pass through untouched; wrap-around belongs to the external adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC <= RESET_VECTOR;
        end else begin
            PC <= next_pc_c;
        end
    end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: a reference model of the next-PC rule is
// compared every cycle, and literal expectations pin the model at key points.
module tb_program_counter;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    pc_t  pc_plus_4;
    pc_t  branch_target;
    logic branch_decision;
    pc_t  PC;

    int   errors = 0;
    int   checks = 0;
    pc_t  model_pc;
    bit   model_valid = 1'b0;

    program_counter dut (
        .clk             (clk),
        .rst             (rst),
        .pc_plus_4       (pc_plus_4),
        .branch_target   (branch_target),
        .branch_decision (branch_decision),
        .PC              (PC)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input pc_t act, input pc_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: PC=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after an edge, PC is the reset vector, else the target or the sequential address.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            model_pc    = 32'h0000_0000;
            model_valid = 1'b1;
        end else if (model_valid) begin
            model_pc = (branch_decision === 1'b1) ? branch_target : pc_plus_4;
        end
        #1;
        if (model_valid) check("model", PC, model_pc);
    end

    // One clock cycle; pc_plus_4 follows the expected PC as the fetch adder would.
    task automatic tick(input logic r, input logic b, input pc_t t);
        rst             = r;
        branch_decision = b;
        branch_target   = t;
        pc_plus_4       = model_pc + 32'd4;
        @(posedge clk);
        #2;
    endtask

    // branch_decision pulses 1 then returns to 0, all between edges.
    task automatic tick_glitch(input pc_t t);
        rst             = 1'b0;
        branch_decision = 1'b0;
        branch_target   = t;
        pc_plus_4       = model_pc + 32'd4;
        #4 branch_decision = 1'b1;
        #4 branch_decision = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        branch_decision = 1'b0;
        branch_target   = 32'h0;
        pc_plus_4       = 32'h0;
        @(posedge clk);
        #2;

        tick(1'b1, 1'b1, 32'h0000_0004);
        check("reset_ignores_branch", PC, 32'h0000_0000);

        tick(1'b0, 1'b0, 32'h0000_0100);
        check("seq_first", PC, 32'h0000_0004);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0000_0100);
        check("seq_fourth", PC, 32'h0000_0010);

        tick(1'b1, 1'b1, 32'h0000_0040);
        check("reset_mid_run", PC, 32'h0000_0000);
        tick(1'b0, 1'b0, 32'h0000_0040);
        check("restart_after_reset", PC, 32'h0000_0004);

        tick(1'b0, 1'b1, 32'h0000_0004);
        check("branch_edge1", PC, 32'h0000_0004);
        tick(1'b0, 1'b1, 32'h0000_0004);
        check("branch_edge2", PC, 32'h0000_0004);
        tick(1'b0, 1'b0, 32'h0000_0004);
        check("resume_after_branch", PC, 32'h0000_0008);

        tick_glitch(32'h0000_0800);
        check("between_edge_glitch", PC, 32'h0000_000C);

        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        check("full_width_target", PC, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0000_0100);
        check("wrap_passthrough", PC, 32'h0000_0000);

        tick(1'b0, 1'b1, 32'h1234_5677);
        check("low_bits_passthrough", PC, 32'h1234_5677);
        tick(1'b0, 1'b0, 32'h0000_0000);
        check("seq_from_odd", PC, 32'h1234_567B);

        tick(1'b1, 1'bx, 32'hDEAD_BEEF);
        check("reset_with_x_decision", PC, 32'h0000_0000);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'hDEAD_BEEF);
        check("seq_after_x_reset", PC, 32'h0000_000C);

        rst = 1'b0;
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_program_counter

// File: doc/program_counter.md
# program_counter

Architectural program-counter register for the single-cycle RISC-V datapath. Each rising clock edge it loads either the sequential address (`pc_plus_4`, computed externally by the fetch adder) or the branch/jump target, as selected by the branch decision from the execute stage. Its `PC` output drives the instruction-memory address and the external PC+4 adder.

## Interface
Parameters:
- `bitwidth`, default 32: width of every address port.
- `RESET_VECTOR`, default 0: value loaded into `PC` on reset. Must fit in `bitwidth` bits.

Ports:
- `clk`, input, 1: single clock; all state updates occur on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `pc_plus_4`, input, `bitwidth`: sequential next address, produced externally from `PC`.
- `branch_target`, input, `bitwidth`: taken branch/jump destination.
- `branch_decision`, input, 1: 1 = take `branch_target`, 0 = take `pc_plus_4`.
- `PC`, output, `bitwidth`: current program counter, driven directly from a register.

## Operation
- Next-PC select is combinational:
  - `next_pc` = `branch_target` when `branch_decision` is 1.
  - `next_pc` = `pc_plus_4` when `branch_decision` is 0.
- Register update at each rising `clk`:
  - `rst`=1: `PC` <= `RESET_VECTOR`. This takes priority over `branch_decision` and both address inputs.
  - `rst`=0: `PC` <= `next_pc`.
- No alignment masking, no increment logic, no overflow handling. Input values pass through unmodified, including the low two bits. Wrap-around is entirely the external adder's responsibility.
- `branch_decision` is sampled only at the clock edge. An X or Z value on it while `rst`=1 has no effect.
- No enable or stall input; `PC` updates every cycle.

## Timing
- Reset value of `PC`: `RESET_VECTOR` (0 by default). It is visible after the first rising edge with `rst`=1.
- `PC` before the first reset edge is undefined. No initial value is relied upon.
- `rst` is synchronous:
  - asserting or deasserting it between edges has no effect until the next rising edge;
  - asserting it mid-run resets `PC` on the next edge, regardless of a pending branch.
- Latency is one cycle: inputs present before edge N appear on `PC` immediately after edge N.
- `PC` is registered; there is no combinational path from any input to `PC`.
- Inputs must be stable for setup/hold around the rising edge. Changes between edges are ignored.
- `branch_decision` held at 1 for several cycles reloads `branch_target` on every such edge.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN` = 32 constant, used for `bitwidth`;
  - `RESET_VECTOR` default constant;
  - `pc_t` address typedef, reused by fetch and branch units.
- One natural sub-module: `pc_next_mux`, a combinational 2:1 `bitwidth` mux selecting `branch_target` or `pc_plus_4`.
- Top level: the mux plus one register process with synchronous reset.

## Test plan
Common bench setup: clock period 20 ns; `pc_plus_4` driven by the bench as `PC`+4, registered on the bench clock.
- **Reset:** `rst`=1 across one rising edge, with `branch_decision`=1 and `branch_target`=0x4. Required: `PC`=0x0 after that edge; the branch is ignored.
- **Sequential run:** `rst`=0, `branch_decision`=0, `pc_plus_4` tracking `PC`+4. Required: `PC` advances by one `pc_plus_4` value per edge, giving a monotonic increasing sequence of multiples of 4, with one-cycle latency from each `pc_plus_4` value.
- **Taken branch:** `branch_decision`=1 for 2 edges with `branch_target`=0x4. Required: `PC`=0x4 after each of those edges. Then set `branch_decision`=0; `PC` resumes from `pc_plus_4` (0x8) on the next edge.
- **Reset mid-run:** with `PC` at 0x10, assert `rst` for one edge. Required: `PC`=0x0 on that edge. After deassertion, the sequence restarts from `pc_plus_4`.
- **Between-edge glitch:** toggle `branch_decision` 1→0 entirely between two edges. Required: `PC` unaffected; only the value sampled at the edge matters.
- **Full-width passthrough:** `branch_target`=0xFFFF_FFFC with `branch_decision`=1. Required: `PC`=0xFFFF_FFFC. Then `pc_plus_4`=0x0000_0000 with `branch_decision`=0. Required: `PC`=0x0, with no masking or modification.
